rom_seq_multiplier: RTL and testbench

// - Unsigned WIDTH x WIDTH multiplier built from a DIGIT x DIGIT lookup-table ROM, iterated over digit pairs.
// - Parametrised, sequential successor to the combinational 2x2 ROM multiplier; no '*' operator is inferred.
// - Sits beside the datapath as a small-area multiply unit driven by a start/done handshake.

---
 rtl/rom_seq_multiplier.sv | 151 +++++++++++++++
 tb/tb_rom_seq_multiplier.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_seq_multiplier.sv
// rom_seq_multiplier: unsigned WIDTH x WIDTH multiply by iterating a
// DIGIT x DIGIT lookup ROM over every digit pair of the two operands.
// Optional build macro: MUL_ZERO_SKIP_EN (zero operands finish in one cycle).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a new request; zero-skip completion also here
// BUSY  | one digit pair per cycle, i outer / j inner
module rom_seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int N      = WIDTH / DIGIT;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int SW     = $clog2(2 * WIDTH) + 1;
  localparam int ROM_SZ = 2 ** (2 * DIGIT);
  localparam int DMASK  = (2 ** DIGIT) - 1;
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [SW-1:0] DSTEP = SW'(DIGIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    a_rem, b_q, b_rem;
  logic [IW-1:0]       i, j;
  logic [SW-1:0]       off_i, off_j;
  logic [2*WIDTH-1:0]  acc, acc_nxt;
  logic [2*DIGIT-1:0]  rom_out;
  logic                last, skip, zpend;

  // Shift-and-add product of two small constants, evaluated at elaboration.
  function automatic logic [2*DIGIT-1:0] rom_entry(input int x, input int y);
    int p;
    p = 0;
    for (int k = 0; k < DIGIT; k++)
      if (((y >> k) & 1) != 0) p = p + (x << k);
    return (2*DIGIT)'(p);
  endfunction

  logic [2*DIGIT-1:0] rom_tbl [ROM_SZ];

  // Constant ROM: index {x,y} holds x*y.
  for (genvar g = 0; g < ROM_SZ; g++) begin : g_rom
    assign rom_tbl[g] = rom_entry(g >> DIGIT, g & DMASK);
  end

  assign rom_out = rom_tbl[{a_rem[DIGIT-1:0], b_rem[DIGIT-1:0]}];
  assign acc_nxt = acc + ((2*WIDTH)'(rom_out) << (off_i + off_j));
  assign last    = (i == LAST) && (j == LAST);

`ifdef MUL_ZERO_SKIP_EN
  assign skip = (a == '0) || (b == '0);
`else
  assign skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start && !skip) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit walk, accumulation and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rem <= '0;
      b_q   <= '0;
      b_rem <= '0;
      i     <= '0;
      j     <= '0;
      off_i <= '0;
      off_j <= '0;
      acc   <= '0;
      prod  <= '0;
      done  <= 1'b0;
      zpend <= 1'b0;
    end else begin
      done  <= 1'b0;
      zpend <= 1'b0;
      // a zero-operand request completes one edge after it was accepted
      if (zpend) begin
        prod <= '0;
        done <= 1'b1;
      end
      if (state == IDLE) begin
        if (start) begin
          if (skip) begin
            zpend <= 1'b1;
          end else begin
            a_rem <= a;
            b_q   <= b;
            b_rem <= b;
            i     <= '0;
            j     <= '0;
            off_i <= '0;
            off_j <= '0;
            acc   <= '0;
          end
        end
      end else begin
        acc <= acc_nxt;
        if (j == LAST) begin
          j     <= '0;
          off_j <= '0;
          b_rem <= b_q;
          i     <= i + IW'(1);
          off_i <= off_i + DSTEP;
          a_rem <= a_rem >> DIGIT;
        end else begin
          j     <= j + IW'(1);
          off_j <= off_j + DSTEP;
          b_rem <= b_rem >> DIGIT;
        end
        if (last) begin
          prod <= acc_nxt;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_seq_multiplier.sv
// Self-checking bench for rom_seq_multiplier: 8-bit default instance plus a
// 4-bit instance for an exhaustive sweep. Reference is plain a*b arithmetic.
module tb_rom_seq_multiplier;

  localparam int K8 = 16;
  localparam int K4 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        ready, busy, done;
  logic [15:0] prod;

  logic        s_start;
  logic [3:0]  s_a, s_b;
  logic        s_ready, s_busy, s_done;
  logic [7:0]  s_prod;

  int total = 0;
  int bad   = 0;

  rom_seq_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .prod(prod)
  );

  rom_seq_multiplier #(.WIDTH(4), .DIGIT(2)) dut4 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b),
    .ready(s_ready), .busy(s_busy), .done(s_done), .prod(s_prod)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input int x, input int y, input int k);
`ifdef MUL_ZERO_SKIP_EN
    if (x == 0 || y == 0) return 1;
`endif
    return k;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [15:0] p, output int bcnt);
    int cyc;
    start = 1'b1; a = x; b = y;
    lat = -1; p = 'x; bcnt = 0; cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (done) begin lat = cyc; p = prod; break; end
      if (busy) bcnt++;
      cyc++;
    end
  endtask

  task automatic check_op(input string nm, input logic [7:0] x, input logic [7:0] y,
                          input int lat, input logic [15:0] p);
    int el;
    logic [15:0] ep;
    el = exp_lat(x, y, K8);
    ep = 16'(int'(x) * int'(y));
    total++;
    if (lat !== el) begin
      bad++;
      $display("FAIL %s latency a=%0d b=%0d got %0d want %0d", nm, x, y, lat, el);
    end
    total++;
    if (p !== ep) begin
      bad++;
      $display("FAIL %s prod a=%0d b=%0d got %0d want %0d", nm, x, y, p, ep);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (prod !== 16'd0) begin bad++; $display("FAIL reset_prod got %0d want 0", prod); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_max();
    int lat, bc;
    logic [15:0] p;
    run_op(8'd255, 8'd255, lat, p, bc);
    check_op("max", 8'd255, 8'd255, lat, p);
    total++; if (bc !== K8) begin bad++; $display("FAIL max_busy_cycles got %0d want %0d", bc, K8); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL max_ready_at_done got %b want 1", ready); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL max_done_width got %b want 0", done); end
    total++; if (prod !== 16'd65025) begin bad++; $display("FAIL max_prod_hold got %0d want 65025", prod); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [15:0] p;
    run_op(8'd13, 8'd11, lat, p, bc);
    check_op("b2b_first", 8'd13, 8'd11, lat, p);
    run_op(8'd3, 8'd3, lat, p, bc);
    check_op("b2b_second", 8'd3, 8'd3, lat, p);
  endtask

  task automatic test_ignore_start();
    int cyc, lat;
    start = 1'b1; a = 8'd7; b = 8'd9;
    cyc = 0; lat = -1;
    while (cyc < 100) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (cyc == 3) begin start = 1'b1; a = 8'd1; b = 8'd1; end
      if (cyc == 4) begin start = 1'b0; a = 8'($urandom); b = 8'($urandom); end
      if (done) begin lat = cyc; break; end
      cyc++;
    end
    total++; if (lat !== K8) begin bad++; $display("FAIL ignore_latency got %0d want %0d", lat, K8); end
    total++; if (prod !== 16'd63) begin bad++; $display("FAIL ignore_prod got %0d want 63", prod); end
  endtask

  task automatic test_reset_mid();
    int seen, lat, bc;
    logic [15:0] p;
    start = 1'b1; a = 8'd200; b = 8'd100;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_done got %0d pulses want 0", seen); end
    total++; if (prod !== 16'd0) begin bad++; $display("FAIL rstmid_prod got %0d want 0", prod); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got %b want 1", ready); end
    run_op(8'd2, 8'd5, lat, p, bc);
    check_op("rstmid_next", 8'd2, 8'd5, lat, p);
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [15:0] p;
    run_op(8'd0, 8'd200, lat, p, bc);
    check_op("zero_a", 8'd0, 8'd200, lat, p);
    run_op(8'd77, 8'd0, lat, p, bc);
    check_op("zero_b", 8'd77, 8'd0, lat, p);
  endtask

  task automatic test_random();
    int lat, bc;
    logic [15:0] p;
    logic [7:0] x, y;
    for (int n = 0; n < 30; n++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      run_op(x, y, lat, p, bc);
      check_op("random", x, y, lat, p);
    end
  endtask

  task automatic test_sweep4();
    int cyc, lat, el;
    logic [7:0] ep;
    int errs;
    errs = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        s_start = 1'b1; s_a = 4'(x); s_b = 4'(y);
        cyc = 0; lat = -1;
        while (cyc < 50) begin
          @(negedge clk);
          if (cyc == 0) s_start = 1'b0;
          if (s_done) begin lat = cyc; break; end
          cyc++;
        end
        el = exp_lat(x, y, K4);
        ep = 8'(x * y);
        total++;
        if (lat !== el || s_prod !== ep) begin
          bad++; errs++;
          if (errs < 10)
            $display("FAIL sweep4 a=%0d b=%0d prod got %0d want %0d lat got %0d want %0d",
                     x, y, s_prod, ep, lat, el);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_zero();
    test_random();
    test_sweep4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
